uart_cmd_parser: RTL and testbench
==================================

Name: uart_cmd_parser

Overview:
- Byte-level command peer that sits on the simple rx/tx byte interface of the system UART.
- Consumes 4-byte command frames from the UART receive side: SYNC, ADDR, DATA, CHK.
- Issues register write or read strobes onto a simple register bus.
- Returns a response frame through the UART transmit side.
- Provides host-PC register access to the capture core over the serial link.

Parameters:
- TIMEOUT_CYCLES, 1000000: inter-byte timeout in clk cycles (about 10 ms at 99 MHz); 0 disables the timeout.
- SYNC_BYTE, 8'hAA: frame start marker.
- ACK_BYTE, 8'h55: response byte for a good frame.
- NAK_BYTE, 8'hEE: response byte for a checksum failure.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- rx_data  in  8  received byte from the UART
- rx_rdy  in  1  UART holds an unread byte
- rx_ack  out  1  one-cycle consume pulse to the UART
- tx_data  out  8  byte to transmit
- tx_rdy  out  1  tx_data valid; held until accepted
- tx_ack  in  1  UART accepts the byte (accepted on an edge with tx_rdy=1 and tx_ack=1)
- reg_addr  out  7  register address, latched from ADDR[6:0]
- reg_wdata  out  8  write data, latched from DATA
- reg_we  out  1  one-cycle write strobe
- reg_re  out  1  one-cycle read strobe
- reg_rdata  in  8  read data; valid the cycle after reg_re
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values (applied asynchronously): all outputs 0; state IDLE; internal latches 0; timeout counter 0.
- Rx handshake:
  - A byte is taken on an edge where rx_rdy=1 and rx_ack=0.
  - rx_ack is registered and high for exactly the next cycle.
  - rx_rdy is ignored while rx_ack=1, because the UART clears it on that edge.
- Tx handshake:
  - tx_rdy and tx_data are registered and held stable until an edge with tx_ack=1.
  - tx_rdy drops the following cycle.
  - Successive response bytes are never presented back-to-back in the same cycle.
- States and transitions:
  - IDLE: take byte. If it equals SYNC_BYTE, go to ADDR; otherwise discard silently.
  - ADDR: take byte into addr_byte; bit7 = read flag. Go to DATA.
  - DATA: take byte into data_byte. Go to CHK.
  - CHK: take byte. If it equals addr_byte^data_byte, go to EXEC; otherwise set the response to NAK_BYTE and go to RESP.
  - EXEC:
    - Write (bit7=0): reg_we=1 for one cycle with reg_addr and reg_wdata stable. Response is ACK_BYTE. Go to RESP.
    - Read (bit7=1): reg_re=1 for one cycle, then capture reg_rdata on the next edge. Response is ACK_BYTE followed by the read data. Go to RESP.
  - RESP: send 1 byte (write or NAK) or 2 bytes (read), then return to IDLE.
- reg_addr and reg_wdata update at CHK acceptance and hold until the next frame reaches EXEC.
- A checksum failure never strobes reg_we or reg_re.
- Timeout:
  - The counter is active only in ADDR, DATA and CHK.
  - It clears on each accepted byte.
  - On reaching TIMEOUT_CYCLES it returns to IDLE without a response and without a strobe.
- While in RESP or EXEC, rx bytes are not consumed. rx_rdy is left pending, and any overrun is the UART's concern.
- A SYNC_BYTE value seen inside ADDR, DATA or CHK is treated as payload; there is no resynchronisation.
- Simultaneous events: timeout expiry and byte arrival on the same edge resolve as byte accepted; the counter clears.
- Reset mid-frame or mid-response: tx_rdy drops immediately; any partial frame is lost.

Optional Feature:
- Macro UART_CMD_ERRCNT_EN.
- When defined:
  - Adds output port err_cnt [7:0], reset value 0.
  - err_cnt increments once per checksum failure and once per timeout, saturating at 8'hFF.
  - err_cnt clears when a write frame with ADDR=7'h7F completes.
  - That write frame is still forwarded to the register bus as usual.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Write frame: bytes AA,05,3C,39 -> reg_we pulses once with reg_addr=05 and reg_wdata=3C; tx sends 55; busy returns to 0.
- Read frame: bytes AA,85,00,85 with reg_rdata=C3 -> reg_re pulses once with reg_addr=05; tx sends 55 then C3 in order; reg_we stays 0.
- Bad checksum: bytes AA,05,3C,00 -> no strobes; tx sends EE; with UART_CMD_ERRCNT_EN, err_cnt=1.
- Junk then frame: bytes 12,FF,AA,01,02,03 -> first two discarded; reg_we fires with addr=01 and data=02; one 55 is sent.
- Timeout: TIMEOUT_CYCLES=100; send AA,05, then idle 100 cycles -> back to IDLE with busy=0; no tx; a subsequent valid frame executes normally.
- Async reset: assert rst while tx_rdy=1 in RESP -> tx_rdy, busy and all strobes go to 0 before the next clk edge; a following frame works.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - UART byte-stream command parser driving a simple register bus
// Optional build macro: UART_CMD_ERRCNT_EN adds the err_cnt error counter output.
`timescale 1ns/1ps
module uart_cmd_parser #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hAA,
    parameter logic [7:0]  ACK_BYTE       = 8'h55,
    parameter logic [7:0]  NAK_BYTE       = 8'hEE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_rdy,
    output logic       rx_ack,
    output logic [7:0] tx_data,
    output logic       tx_rdy,
    input  logic       tx_ack,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
`ifdef UART_CMD_ERRCNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_CHK,
        S_EXEC,
        S_RDWAIT,
        S_RESP
    } state_t;

    localparam int unsigned    TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state;
    state_t          state_nx;
    logic [7:0]      addr_byte;
    logic [7:0]      data_byte;
    logic [7:0]      rd_byte;
    logic            nak;
    logic            tx_idx;
    logic [TO_W-1:0] to_cnt;

    logic in_frame;
    logic can_take;
    logic take;
    logic chk_ok;
    logic timeout_hit;
    logic tx_last;
    logic tx_done;

    // Only the frame-collecting states consume rx bytes; EXEC/RESP leave rx_rdy pending.
    assign in_frame    = (state == S_ADDR) || (state == S_DATA) || (state == S_CHK);
    assign can_take    = (state == S_IDLE) || in_frame;
    assign take        = can_take && rx_rdy && !rx_ack;
    assign chk_ok      = (rx_data == (addr_byte ^ data_byte));
    // A byte arriving on the expiry edge wins over the timeout.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && in_frame && !take && (to_cnt == TO_LAST);
    // Reads answer with ACK plus data; writes and NAKs are a single byte.
    assign tx_last     = addr_byte[7] && !nak;
    assign tx_done     = tx_rdy && tx_ack && (tx_idx == tx_last);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and the state-derived bus strobes.
    always_comb begin
        state_nx = state;
        reg_we   = 1'b0;
        reg_re   = 1'b0;
        busy     = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (take && (rx_data == SYNC_BYTE)) begin
                    state_nx = S_ADDR;
                end
            end
            S_ADDR: begin
                if (take) begin
                    state_nx = S_DATA;
                end else if (timeout_hit) begin
                    state_nx = S_IDLE;
                end
            end
            S_DATA: begin
                if (take) begin
                    state_nx = S_CHK;
                end else if (timeout_hit) begin
                    state_nx = S_IDLE;
                end
            end
            S_CHK: begin
                if (take) begin
                    state_nx = chk_ok ? S_EXEC : S_RESP;
                end else if (timeout_hit) begin
                    state_nx = S_IDLE;
                end
            end
            S_EXEC: begin
                reg_we   = !addr_byte[7];
                reg_re   = addr_byte[7];
                state_nx = addr_byte[7] ? S_RDWAIT : S_RESP;
            end
            S_RDWAIT: begin
                state_nx = S_RESP;
            end
            S_RESP: begin
                if (tx_done) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Inter-byte timeout counter, cleared on every accepted byte and outside a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (!in_frame || take || timeout_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Rx consume pulse and frame field capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_ack    <= 1'b0;
            addr_byte <= '0;
            data_byte <= '0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            nak       <= 1'b0;
            rd_byte   <= '0;
        end else begin
            rx_ack <= take;
            if (take && (state == S_ADDR)) begin
                addr_byte <= rx_data;
            end
            if (take && (state == S_DATA)) begin
                data_byte <= rx_data;
            end
            if (take && (state == S_CHK)) begin
                reg_addr  <= addr_byte[6:0];
                reg_wdata <= data_byte;
                nak       <= !chk_ok;
            end
            // Read data is valid the cycle after the reg_re strobe.
            if (state == S_RDWAIT) begin
                rd_byte <= reg_rdata;
            end
        end
    end

    // Response transmitter: one byte at a time, with a dead cycle after each acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_rdy  <= 1'b0;
            tx_data <= '0;
            tx_idx  <= 1'b0;
        end else if (state != S_RESP) begin
            tx_rdy <= 1'b0;
            tx_idx <= 1'b0;
        end else if (tx_rdy) begin
            if (tx_ack) begin
                tx_rdy <= 1'b0;
                tx_idx <= 1'b1;
            end
        end else begin
            tx_rdy  <= 1'b1;
            tx_data <= tx_idx ? rd_byte : (nak ? NAK_BYTE : ACK_BYTE);
        end
    end

`ifdef UART_CMD_ERRCNT_EN
    // Saturating count of checksum failures and timeouts; a write to 0x7F clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if ((take && (state == S_CHK) && !chk_ok) || timeout_hit) begin
            if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end else if ((state == S_EXEC) && !addr_byte[7] && (addr_byte[6:0] == 7'h7F)) begin
            err_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - self-checking bench for uart_cmd_parser (frame-level reference model)
`timescale 1ns/1ps
module tb_uart_cmd_parser;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       rx_ack;
    logic [7:0] tx_data;
    logic       tx_rdy;
    logic       tx_ack;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;
`ifdef UART_CMD_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    uart_cmd_parser #(.TIMEOUT_CYCLES(100)) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_rdy(rx_rdy),
        .rx_ack(rx_ack),
        .tx_data(tx_data),
        .tx_rdy(tx_rdy),
        .tx_ack(tx_ack),
        .reg_addr(reg_addr),
        .reg_wdata(reg_wdata),
        .reg_we(reg_we),
        .reg_re(reg_re),
        .reg_rdata(reg_rdata),
`ifdef UART_CMD_ERRCNT_EN
        .busy(busy),
        .err_cnt(err_cnt)
`else
        .busy(busy)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: partial frame and expected bus/tx events.
    logic [7:0]  fb[$];
    logic [14:0] exp_wr[$];
    logic [6:0]  exp_rd[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  tx_log[$];
    int          m_err = 0;
    logic        tx_hold = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame rules: hunt for sync, collect 4 bytes, checksum = addr ^ data.
    task automatic model_byte(input logic [7:0] b);
        if (fb.size() == 0) begin
            if (b == 8'hAA) fb.push_back(b);
        end else begin
            fb.push_back(b);
            if (fb.size() == 4) begin
                if ((fb[1] ^ fb[2]) == fb[3]) begin
                    exp_tx.push_back(8'h55);
                    if (fb[1][7]) begin
                        exp_rd.push_back(fb[1][6:0]);
                        exp_tx.push_back(reg_rdata);
                    end else begin
                        exp_wr.push_back({fb[1][6:0], fb[2]});
                        if (fb[1][6:0] == 7'h7F) m_err = 0;
                    end
                end else begin
                    exp_tx.push_back(8'hEE);
                    if (m_err != 255) m_err++;
                end
                fb.delete();
            end
        end
    endtask

    task automatic model_timeout();
        if (fb.size() != 0) begin
            fb.delete();
            if (m_err != 255) m_err++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge clk);
        rx_data = b;
        rx_rdy  = 1'b1;
        model_byte(b);
        n = 0;
        while (!rx_ack && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("rx_ack_seen", rx_ack, 1'b1);
        rx_rdy = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || exp_tx.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({name, "_busy"}, busy, 1'b0);
        check({name, "_tx_left"}, exp_tx.size(), 0);
        check({name, "_wr_left"}, exp_wr.size(), 0);
        check({name, "_rd_left"}, exp_rd.size(), 0);
`ifdef UART_CMD_ERRCNT_EN
        check({name, "_err_cnt"}, err_cnt, m_err);
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Per-cycle compare process; also plays the UART transmit side.
    initial begin
        logic       prev_rdy;
        logic       prev_acc;
        logic [7:0] prev_data;
        logic       gap_req;
        logic       prev_rx_ack;
        int         tx_wait;
        prev_rdy = 0; prev_acc = 0; prev_data = 0; gap_req = 0; prev_rx_ack = 0; tx_wait = 0;
        tx_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_rdy = 0; prev_acc = 0; gap_req = 0; prev_rx_ack = 0; tx_wait = 0;
                tx_ack = 1'b0;
            end else begin
                if (reg_we) begin
                    if (exp_wr.size() == 0) check("reg_we_spurious", reg_we, 1'b0);
                    else check("reg_we_fields", {reg_addr, reg_wdata}, exp_wr.pop_front());
                end
                if (reg_re) begin
                    if (exp_rd.size() == 0) check("reg_re_spurious", reg_re, 1'b0);
                    else check("reg_re_addr", reg_addr, exp_rd.pop_front());
                end
                if (reg_we && reg_re) check("we_re_both", reg_re, 1'b0);
                if (prev_rx_ack) check("rx_ack_one_cycle", rx_ack, 1'b0);
                prev_rx_ack = rx_ack;
                if (tx_rdy) begin
                    if (gap_req) check("tx_gap_after_accept", tx_rdy, 1'b0);
                    if (prev_rdy && !prev_acc) check("tx_data_held", tx_data, prev_data);
                    prev_rdy  = 1'b1;
                    prev_data = tx_data;
                    if (!tx_hold && tx_wait >= 1) begin
                        tx_ack = 1'b1;
                        if (exp_tx.size() == 0) check("tx_spurious", tx_rdy, 1'b0);
                        else check("tx_byte", tx_data, exp_tx.pop_front());
                        tx_log.push_back(tx_data);
                        prev_acc = 1'b1;
                        gap_req  = 1'b1;
                        tx_wait  = 0;
                    end else begin
                        tx_ack   = 1'b0;
                        prev_acc = 1'b0;
                        gap_req  = 1'b0;
                        tx_wait++;
                    end
                end else begin
                    tx_ack   = 1'b0;
                    prev_rdy = 1'b0;
                    prev_acc = 1'b0;
                    gap_req  = 1'b0;
                    tx_wait  = 0;
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; rx_data = 8'h00; rx_rdy = 1'b0; reg_rdata = 8'h00;
        idle(3);
        check("rst_tx_rdy", tx_rdy, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rx_ack", rx_ack, 1'b0);
        check("rst_we_re", {reg_we, reg_re}, 2'b00);
        check("rst_reg_addr", reg_addr, 7'h00);
        check("rst_reg_wdata", reg_wdata, 8'h00);
        check("rst_tx_data", tx_data, 8'h00);
`ifdef UART_CMD_ERRCNT_EN
        check("rst_err_cnt", err_cnt, 8'h00);
`endif
        rst = 1'b0;
        idle(2);

        // Write frame
        tx_log.delete();
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C); send_byte(8'h39);
        wait_idle("write");
        check("write_reg_addr", reg_addr, 7'h05);
        check("write_reg_wdata", reg_wdata, 8'h3C);
        check("write_tx_count", tx_log.size(), 1);
        if (tx_log.size() >= 1) check("write_tx0", tx_log[0], 8'h55);

        // Read frame
        tx_log.delete();
        reg_rdata = 8'hC3;
        send_byte(8'hAA); send_byte(8'h85); send_byte(8'h00); send_byte(8'h85);
        wait_idle("read");
        check("read_reg_addr", reg_addr, 7'h05);
        check("read_tx_count", tx_log.size(), 2);
        if (tx_log.size() >= 2) begin
            check("read_tx0", tx_log[0], 8'h55);
            check("read_tx1", tx_log[1], 8'hC3);
        end

        // Bad checksum
        tx_log.delete();
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C); send_byte(8'h00);
        wait_idle("badchk");
        check("badchk_tx_count", tx_log.size(), 1);
        if (tx_log.size() >= 1) check("badchk_tx0", tx_log[0], 8'hEE);
`ifdef UART_CMD_ERRCNT_EN
        check("badchk_err_cnt_lit", err_cnt, 8'h01);
`endif

        // Junk then frame
        tx_log.delete();
        send_byte(8'h12); send_byte(8'hFF);
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        wait_idle("junk");
        check("junk_reg_addr", reg_addr, 7'h01);
        check("junk_reg_wdata", reg_wdata, 8'h02);
        check("junk_tx_count", tx_log.size(), 1);

        // Timeout after two bytes, then recovery frames
        tx_log.delete();
        send_byte(8'hAA); send_byte(8'h05);
        idle(95);
        check("timeout_still_busy", busy, 1'b1);
        idle(10);
        check("timeout_idle", busy, 1'b0);
        model_timeout();
        wait_idle("timeout");
        check("timeout_no_tx", tx_log.size(), 0);
        // SYNC value as address payload: read of 0x2A
        reg_rdata = 8'h5A;
        send_byte(8'hAA); send_byte(8'hAA); send_byte(8'h10); send_byte(8'hBA);
        wait_idle("syncpay");
        check("syncpay_reg_addr", reg_addr, 7'h2A);
        check("syncpay_tx_count", tx_log.size(), 2);
        // Write to 0x7F clears the error counter and is still forwarded
        send_byte(8'hAA); send_byte(8'h7F); send_byte(8'h00); send_byte(8'h7F);
        wait_idle("clr");
        check("clr_reg_addr", reg_addr, 7'h7F);
`ifdef UART_CMD_ERRCNT_EN
        check("clr_err_cnt_lit", err_cnt, 8'h00);
`endif

        // Async reset while a response byte is pending
        tx_log.delete();
        tx_hold = 1'b1;
        send_byte(8'hAA); send_byte(8'h03); send_byte(8'h04); send_byte(8'h07);
        n = 0;
        while (!tx_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("arst_tx_rdy_before", tx_rdy, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_tx_rdy", tx_rdy, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_strobes", {reg_we, reg_re}, 2'b00);
        exp_tx.delete(); exp_wr.delete(); exp_rd.delete(); fb.delete();
        m_err = 0;
        tx_hold = 1'b0;
        idle(2);
        rst = 1'b0;
        idle(1);
        send_byte(8'hAA); send_byte(8'h06); send_byte(8'h07); send_byte(8'h01);
        wait_idle("post_rst");
        check("post_rst_reg_addr", reg_addr, 7'h06);
        check("post_rst_reg_wdata", reg_wdata, 8'h07);
        check("post_rst_tx_count", tx_log.size(), 1);
        if (tx_log.size() >= 1) check("post_rst_tx0", tx_log[0], 8'h55);

        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
